// File: rtl/osd_pkg.sv
// osd_pkg: shared state encoding, glyph indices/encoding and colour defaults
// for the on-screen glyph overlay scheduler.
package osd_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SHOW} state_t;

   localparam logic [2:0] GLY_0 = 3'd0;
   localparam logic [2:0] GLY_1 = 3'd1;
   localparam logic [2:0] GLY_2 = 3'd2;
   localparam logic [2:0] GLY_3 = 3'd3;
   localparam logic [2:0] GLY_4 = 3'd4;

   localparam logic [23:0] COL_FRONT   = 24'hFFFFFF;
   localparam logic [23:0] COL_BACK    = 24'h000000;
   localparam logic [23:0] COL_DEFAULT = 24'h000000;

   // Glyph 4 and the unused indices 5..7 select no LED segment.
   function automatic logic [3:0] glyph_enc(input logic [2:0] g);
      case (g)
         GLY_0:   glyph_enc = 4'b0001;
         GLY_1:   glyph_enc = 4'b0010;
         GLY_2:   glyph_enc = 4'b0100;
         GLY_3:   glyph_enc = 4'b1000;
         default: glyph_enc = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/osd_prio_arb.sv
// osd_prio_arb: fixed-priority arbiter, lowest index wins among the requests
// left after masking; returns a one-hot grant and its binary index.
module osd_prio_arb
   import osd_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [N-1:0] m;

   assign m     = req & mask;
   assign any   = |m;
   assign grant = m & (~m + 1'b1);

   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (m[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/osd_overlay_ctrl.sv
// osd_overlay_ctrl: frame-synchronous overlay slot scheduler; arbitrates glyph
// requests and applies, holds, blinks and blanks them only at frame start.
module osd_overlay_ctrl
   import osd_pkg::*;
#(
   parameter int          NUM_REQ        = 4,
   parameter logic [7:0]  HOLD_FRAMES    = 8'd120,
   parameter logic [7:0]  BLINK_FRAMES   = 8'd15,
   parameter logic        VS_POL         = 1'b1,
   parameter logic [23:0] FRONT_COLOUR   = COL_FRONT,
   parameter logic [23:0] BACK_COLOUR    = COL_BACK,
   parameter logic [23:0] DEFAULT_COLOUR = COL_DEFAULT,
   localparam int         IW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 pixel_clk,
   input  logic                 rst_n,
   input  logic                 vs_in,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*3-1:0] req_glyph,
   input  logic [NUM_REQ-1:0]   req_blink,
   input  logic                 cancel,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic [3:0]           led_sel,
   output logic [23:0]          front_colour,
   output logic [23:0]          back_colour,
   output logic [23:0]          default_colour,
   output logic                 overlay_active,
   output logic [IW-1:0]        cur_owner
);

   state_t               state_q, state_d;
   logic                 vs_s1_q, vs_s2_q;
   logic                 cancel_q, cancel_d;
   logic [2:0]           pend_glyph_q, pend_glyph_d;
   logic                 pend_blink_q, pend_blink_d;
   logic [IW-1:0]        pend_owner_q, pend_owner_d;
   logic                 show_blink_q, show_blink_d;
   logic [7:0]           hold_q, hold_d;
   logic [7:0]           bcnt_q, bcnt_d;
   logic                 phase_q, phase_d;
   logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
   logic [3:0]           led_sel_q, led_sel_d;
   logic [23:0]          front_q, front_d;
   logic [23:0]          back_q, back_d;
   logic                 active_q, active_d;
   logic [IW-1:0]        owner_q, owner_d;

   logic                 fs;
   logic [NUM_REQ-1:0]   hmask;
   logic [NUM_REQ-1:0]   grant;
   logic [IW-1:0]        gidx;
   logic                 gany;
   logic                 gnt_ok;
   logic                 blank;
   logic                 wrap;

   assign fs     = (vs_s1_q == VS_POL) && (vs_s2_q != VS_POL);
   // Outside IDLE only requesters strictly above the latest grant may pre-empt.
   assign hmask  = (state_q == ST_IDLE) ? '1 : (NUM_REQ'(1) << pend_owner_q) - NUM_REQ'(1);
   assign gnt_ok = gany && !cancel && !cancel_q;
   assign wrap   = show_blink_q && (bcnt_q == 8'd0);

   osd_prio_arb #(.N(NUM_REQ), .IW(IW)) u_arb (
      .req   (req),
      .mask  (hmask),
      .grant (grant),
      .idx   (gidx),
      .any   (gany)
   );

   always_comb begin
      state_d      = state_q;
      cancel_d     = cancel_q | cancel;
      pend_glyph_d = pend_glyph_q;
      pend_blink_d = pend_blink_q;
      pend_owner_d = pend_owner_q;
      show_blink_d = show_blink_q;
      hold_d       = hold_q;
      bcnt_d       = bcnt_q;
      phase_d      = phase_q;
      req_ack_d    = '0;
      led_sel_d    = led_sel_q;
      front_d      = front_q;
      back_d       = back_q;
      active_d     = active_q;
      owner_d      = owner_q;
      blank        = 1'b0;
      if (fs && cancel_q) begin
         state_d      = ST_IDLE;
         cancel_d     = cancel;
         pend_glyph_d = GLY_0;
         pend_blink_d = 1'b0;
         pend_owner_d = '0;
         blank        = 1'b1;
      end else begin
         if (fs && state_q == ST_ARM) begin
            state_d      = ST_SHOW;
            led_sel_d    = glyph_enc(pend_glyph_q);
            front_d      = FRONT_COLOUR;
            back_d       = BACK_COLOUR;
            active_d     = 1'b1;
            owner_d      = pend_owner_q;
            show_blink_d = pend_blink_q;
            hold_d       = HOLD_FRAMES - 8'd1;
            bcnt_d       = BLINK_FRAMES - 8'd1;
            phase_d      = 1'b0;
         end else if (fs && state_q == ST_SHOW) begin
            if (hold_q == 8'd0) begin
               state_d = ST_IDLE;
               blank   = 1'b1;
            end else begin
               hold_d  = hold_q - 8'd1;
               bcnt_d  = !show_blink_q ? bcnt_q : wrap ? BLINK_FRAMES - 8'd1 : bcnt_q - 8'd1;
               phase_d = phase_q ^ wrap;
               front_d = (phase_q ^ wrap) ? BACK_COLOUR : FRONT_COLOUR;
            end
         end
         if (gnt_ok) begin
            state_d      = ST_ARM;
            req_ack_d    = grant;
            pend_glyph_d = req_glyph[int'(gidx)*3 +: 3];
            pend_blink_d = req_blink[gidx];
            pend_owner_d = gidx;
         end
      end
      if (blank) begin
         led_sel_d = 4'b0000;
         front_d   = DEFAULT_COLOUR;
         back_d    = DEFAULT_COLOUR;
         active_d  = 1'b0;
      end
   end

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         vs_s1_q      <= ~VS_POL;
         vs_s2_q      <= ~VS_POL;
         cancel_q     <= 1'b0;
         pend_glyph_q <= GLY_0;
         pend_blink_q <= 1'b0;
         pend_owner_q <= '0;
         show_blink_q <= 1'b0;
         hold_q       <= 8'd0;
         bcnt_q       <= 8'd0;
         phase_q      <= 1'b0;
         req_ack_q    <= '0;
         led_sel_q    <= 4'b0000;
         front_q      <= DEFAULT_COLOUR;
         back_q       <= DEFAULT_COLOUR;
         active_q     <= 1'b0;
         owner_q      <= '0;
      end else begin
         state_q      <= state_d;
         vs_s1_q      <= vs_in;
         vs_s2_q      <= vs_s1_q;
         cancel_q     <= cancel_d;
         pend_glyph_q <= pend_glyph_d;
         pend_blink_q <= pend_blink_d;
         pend_owner_q <= pend_owner_d;
         show_blink_q <= show_blink_d;
         hold_q       <= hold_d;
         bcnt_q       <= bcnt_d;
         phase_q      <= phase_d;
         req_ack_q    <= req_ack_d;
         led_sel_q    <= led_sel_d;
         front_q      <= front_d;
         back_q       <= back_d;
         active_q     <= active_d;
         owner_q      <= owner_d;
      end
   end

   assign req_ack        = req_ack_q;
   assign led_sel        = led_sel_q;
   assign front_colour   = front_q;
   assign back_colour    = back_q;
   assign default_colour = DEFAULT_COLOUR;
   assign overlay_active = active_q;
   assign cur_owner      = owner_q;

endmodule

// File: tb/tb_osd_overlay_ctrl.sv
// tb_osd_overlay_ctrl: frame-level reference model feeding ack and display
// scoreboards; a monitor pops and compares them as the DUT responds.
module tb_osd_overlay_ctrl;

   localparam int          FP    = 24;
   localparam int          HOLD  = 3;
   localparam int          BLINK = 1;
   localparam logic [23:0] FG    = 24'hFFFFFF;
   localparam logic [23:0] BG    = 24'h000000;
   localparam logic [23:0] DF    = 24'h000000;

   logic        pixel_clk = 1'b0;
   logic        rst_n     = 1'b0;
   logic        vs_in     = 1'b0;
   logic        cancel    = 1'b0;
   logic [3:0]  req       = '0;
   logic [11:0] req_glyph = '0;
   logic [3:0]  req_blink = '0;
   logic [3:0]  req_ack, led_sel;
   logic [23:0] front_colour, back_colour, default_colour;
   logic        overlay_active;
   logic [1:0]  cur_owner;

   always #5 pixel_clk = ~pixel_clk;

   osd_overlay_ctrl #(
      .NUM_REQ(4), .HOLD_FRAMES(8'(HOLD)), .BLINK_FRAMES(8'(BLINK)), .VS_POL(1'b1),
      .FRONT_COLOUR(FG), .BACK_COLOUR(BG), .DEFAULT_COLOUR(DF)
   ) dut (
      .pixel_clk(pixel_clk), .rst_n(rst_n), .vs_in(vs_in), .req(req),
      .req_glyph(req_glyph), .req_blink(req_blink), .cancel(cancel),
      .req_ack(req_ack), .led_sel(led_sel), .front_colour(front_colour),
      .back_colour(back_colour), .default_colour(default_colour),
      .overlay_active(overlay_active), .cur_owner(cur_owner)
   );

   typedef struct packed {
      logic [3:0]  led;
      logic        act;
      logic [1:0]  own;
      logic [23:0] fc;
      logic [23:0] bc;
   } snap_t;

   snap_t      snap_q[$];
   logic [3:0] ack_q[$];
   int         n_chk = 0;
   int         n_fail = 0;
   bit         snap_stb = 0;

   // Reference model: what is on screen, what is waiting, who is still asking.
   bit         m_act, m_b, m_pv, m_pb, m_cf;
   logic [1:0] m_o, m_po;
   logic [2:0] m_g, m_pg;
   int         m_shown;
   bit         m_held[4];
   logic [2:0] m_hg[4];
   bit         m_hb[4];

   function automatic snap_t model_snap();
      snap_t s;
      s.act = m_act;
      s.led = (m_act && m_g < 3'd4) ? 4'(1 << m_g) : 4'b0000;
      s.own = m_act ? m_o : 2'b00;
      s.fc  = !m_act ? DF : (m_b && ((m_shown - 1) / BLINK) % 2 == 1) ? BG : FG;
      s.bc  = m_act ? BG : DF;
      return s;
   endfunction

   function automatic void model_fs();
      if (m_cf) begin
         m_cf  = 0;
         m_act = 0;
         m_pv  = 0;
      end else if (m_pv) begin
         m_act = 1; m_o = m_po; m_g = m_pg; m_b = m_pb; m_shown = 1; m_pv = 0;
      end else if (m_act) begin
         if (m_shown == HOLD) m_act = 0;
         else m_shown++;
      end
   endfunction

   function automatic void model_grant();
      int lim;
      if (m_cf) return;
      lim = m_pv ? int'(m_po) : m_act ? int'(m_o) : 4;
      for (int i = 0; i < 4; i++) begin
         if (m_held[i] && i < lim) begin
            m_pv = 1; m_po = 2'(i); m_pg = m_hg[i]; m_pb = m_hb[i]; m_held[i] = 0;
            ack_q.push_back(4'(1 << i));
            break;
         end
      end
   endfunction

   function automatic void model_reset();
      m_act = 0; m_pv = 0; m_cf = 0; m_shown = 0;
      for (int i = 0; i < 4; i++) m_held[i] = 0;
      ack_q.delete();
      snap_q.delete();
   endfunction

   always @(negedge pixel_clk) begin
      snap_t      e, g;
      logic [3:0] ea;
      if (rst_n) begin
         if (req_ack != 4'b0000) begin
            n_chk++;
            if (ack_q.size() == 0) begin
               n_fail++;
               $display("FAIL ack: got %b, expected no ack", req_ack);
            end else begin
               ea = ack_q.pop_front();
               if (req_ack !== ea) begin
                  n_fail++;
                  $display("FAIL ack: got %b, expected %b", req_ack, ea);
               end
            end
         end
         if (snap_stb) begin
            n_chk++;
            g = '{led_sel, overlay_active, overlay_active ? cur_owner : 2'b00, front_colour, back_colour};
            if (snap_q.size() == 0) begin
               n_fail++;
               $display("FAIL display: no expected frame queued");
            end else begin
               e = snap_q.pop_front();
               if (g !== e || default_colour !== DF) begin
                  n_fail++;
                  $display("FAIL display: got led=%b act=%b own=%0d fc=%h bc=%h dc=%h, expected led=%b act=%b own=%0d fc=%h bc=%h dc=%h",
                           g.led, g.act, g.own, g.fc, g.bc, default_colour, e.led, e.act, e.own, e.fc, e.bc, DF);
               end
            end
         end
      end
   end

   task automatic run_frame(input logic [3:0] nr, input logic [11:0] gl, input logic [3:0] bl, input bit cx);
      model_fs();
      model_grant();
      snap_q.push_back(model_snap());
      for (int c = 0; c < FP; c++) begin
         @(posedge pixel_clk);
         #1;
         req      = req & ~req_ack;
         vs_in    = (c < 4);
         cancel   = 1'b0;
         snap_stb = (c == 16);
         if (c == 8) begin
            for (int i = 0; i < 4; i++) begin
               if (nr[i] && !m_held[i]) begin
                  m_held[i] = 1; m_hg[i] = gl[3*i +: 3]; m_hb[i] = bl[i];
                  req[i] = 1'b1; req_glyph[3*i +: 3] = gl[3*i +: 3]; req_blink[i] = bl[i];
               end
            end
            cancel = cx;
            if (cx) m_cf = 1;
            else model_grant();
         end
      end
   endtask

   task automatic idle_frames(input int n);
      for (int k = 0; k < n; k++) run_frame(4'b0000, 12'h000, 4'b0000, 1'b0);
   endtask

   task automatic mid_reset();
      #2;
      n_chk++;
      if (overlay_active !== m_act) begin
         n_fail++;
         $display("FAIL pre_reset_active: got %b, expected %b", overlay_active, m_act);
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (overlay_active !== 1'b0 || led_sel !== 4'b0000) begin
         n_fail++;
         $display("FAIL async_reset: got act=%b led=%b, expected act=0 led=0000", overlay_active, led_sel);
      end
      req = '0; cancel = 1'b0;
      model_reset();
      repeat (3) @(posedge pixel_clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge pixel_clk);
      #1 rst_n = 1'b1;
      n_chk++;
      if (led_sel !== 4'b0000 || overlay_active !== 1'b0 || front_colour !== DF || back_colour !== DF ||
          default_colour !== DF || req_ack !== 4'b0000 || cur_owner !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state: got led=%b act=%b fc=%h bc=%h dc=%h ack=%b own=%0d, expected all blank",
                  led_sel, overlay_active, front_colour, back_colour, default_colour, req_ack, cur_owner);
      end
      idle_frames(5);
      run_frame(4'b0100, 12'h040, 4'b0000, 1'b0);
      idle_frames(4);
      run_frame(4'b0100, 12'h0C0, 4'b0000, 1'b0);
      idle_frames(1);
      run_frame(4'b1001, 12'h002, 4'b0000, 1'b0);
      idle_frames(8);
      run_frame(4'b0010, 12'h000, 4'b0010, 1'b0);
      idle_frames(4);
      run_frame(4'b0010, 12'h018, 4'b0000, 1'b0);
      idle_frames(1);
      run_frame(4'b0001, 12'h004, 4'b0000, 1'b1);
      idle_frames(5);
      run_frame(4'b1000, 12'h000, 4'b0000, 1'b0);
      idle_frames(2);
      mid_reset();
      run_frame(4'b0100, 12'h100, 4'b0000, 1'b0);
      idle_frames(4);
      for (int k = 0; k < 80; k++) begin
         run_frame(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000, 12'($urandom), 4'($urandom),
                   $urandom_range(0, 9) == 0);
      end
      idle_frames(20);
      n_chk++;
      if (ack_q.size() != 0) begin
         n_fail++;
         $display("FAIL ack_drain: got %0d acks never seen, expected 0", ack_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/osd_overlay_ctrl.md
Name: osd_overlay_ctrl

Overview:
- Frame-synchronous scheduler for the on-screen glyph overlay renderer. The renderer takes a 4-bit one-hot glyph select and front, back and default colours.
- Up to NUM_REQ requesters (e.g. voice-effect selector, volume, mode key) compete for the single overlay slot under fixed priority.
- The block latches the winner and applies changes only at frame start, so there is no tearing. It holds the glyph for a set number of frames, optionally blinks it, then blanks it.
- Sits between the control logic and the renderer in the pixel_clk domain.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 has the highest priority.
- HOLD_FRAMES, 8'd120, number of frames a granted glyph stays visible (1..255).
- BLINK_FRAMES, 8'd15, number of frames per blink phase (1..255).
- VS_POL, 1'b1, active level of vs_in.
- FRONT_COLOUR, 24'hFFFFFF, glyph pixel colour.
- BACK_COLOUR, 24'h000000, glyph box background colour.
- DEFAULT_COLOUR, 24'h000000, colour outside the box; also used for the box while the overlay is blanked.

Ports:
- pixel_clk  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- vs_in  in  1  vertical sync from the video input timing.
- req  in  NUM_REQ  level request; held until acked.
- req_glyph  in  NUM_REQ*3  glyph index per requester, 0..4; slot i is bits [3i+2:3i].
- req_blink  in  NUM_REQ  blink enable per requester.
- cancel  in  1  one-cycle pulse that blanks the overlay at the next frame start.
- req_ack  out  NUM_REQ  one-cycle one-hot grant pulse.
- led_sel  out  4  glyph select to the renderer.
- front_colour  out  24  to the renderer.
- back_colour  out  24  to the renderer.
- default_colour  out  24  to the renderer.
- overlay_active  out  1  high while a glyph is displayed.
- cur_owner  out  2  index of the displayed requester; valid when overlay_active is high.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; req_ack=0; led_sel=4'b0000; overlay_active=0; cur_owner=0.
  - All three colour outputs=DEFAULT_COLOUR; frame and blink counters=0; pending glyph cleared.
- frame_start:
  - vs_in is registered once.
  - frame_start is a one-cycle pulse on the cycle after the registered vs_in makes its transition to active level VS_POL.
  - frame_start is therefore 1 cycle after vs_in goes active.
  - Reset sets the registered vs_in to the inactive level, so the first frame after reset is detected.
- Glyph encoding for led_sel: 0→0001, 1→0010, 2→0100, 3→1000, 4→0000. Indices 5..7 are treated as 4.
- Arbitration: fixed priority, lowest index wins, combinational. A grant produces req_ack[i]=1 for one cycle, registered in the same edge that latches glyph/blink/owner into pending.
- States:
  - IDLE:
    - Any req → grant, go to ARM.
    - Outputs stay blank: all colours=DEFAULT_COLOUR, overlay_active=0.
  - ARM:
    - Wait for frame_start.
    - A strictly higher-priority req arriving here is granted and replaces pending; the earlier grant is dropped silently.
    - On frame_start go to SHOW. At that edge: led_sel=encode(pending glyph), front_colour=FRONT_COLOUR, back_colour=BACK_COLOUR, overlay_active=1, cur_owner=pending owner, hold counter=HOLD_FRAMES-1, blink counter=BLINK_FRAMES-1, blink phase=0.
  - SHOW:
    - On each frame_start: if hold counter==0 → IDLE and blank outputs at that edge; else decrement.
    - Net result: the glyph is visible for exactly HOLD_FRAMES frames.
    - Blink: when the latched blink is set, the blink counter decrements each frame_start. On reaching 0 it reloads and toggles the phase. In phase 1, front_colour=BACK_COLOUR, so the glyph is hidden inside the box.
    - A strictly higher-priority req is granted and moves the block to ARM. The old glyph stays displayed until the next frame_start, then the new one appears with no blank frame.
    - An equal- or lower-priority req is not acked and stays pending. It is granted after the block returns to IDLE.
- cancel:
  - Sets a sticky cancel flag.
  - At the next frame_start: blank outputs, state=IDLE, drop pending, clear the flag.
  - While the flag is set, no grants are issued.
  - cancel and req in the same cycle: cancel wins and no ack is issued.
- frame_start coinciding with a grant in IDLE: the glyph is applied at the following frame_start, not the current one.
- Reset mid-SHOW: outputs are blanked immediately (async).
- Registered outputs: all outputs are registered; no combinational path exists from req to the outputs.

Decomposition:
- Package osd_pkg:
  - state encoding (IDLE, ARM, SHOW);
  - glyph index constants GLY_0..GLY_4 and the glyph-to-led_sel encode function;
  - colour defaults.
- Sub-module osd_prio_arb: parameterised fixed-priority arbiter. Outputs a one-hot grant and a binary index from req masked by a "higher-than-owner" mask.

Test Plan (HOLD_FRAMES=3, BLINK_FRAMES=1, frame period shortened):
- Reset, no req, 5 frames → led_sel=0000, overlay_active=0, all colours=DEFAULT_COLOUR throughout.
- req[2] with glyph 1 in IDLE → req_ack=0100 for 1 cycle. At the next frame_start: led_sel=0010, overlay_active=1, cur_owner=2. Exactly 3 frames later: blank.
- Overlay owned by req[2], then req[3] and req[0] asserted → req[0] is acked at once and its glyph appears at the next frame_start. req[3] is acked only after req[0]'s 3 frames expire.
- req[1] with blink=1 → front_colour alternates FFFFFF/000000 on successive frames. back_colour stays 000000.
- Glyph visible, then cancel pulsed with req[0] held high the same cycle → no ack that cycle. Overlay blanks at the next frame_start. req[0] is then acked in IDLE.
- rst_n dropped mid-SHOW → overlay_active=0 and led_sel=0000 with no clock edge. After release, the first vs_in edge yields frame_start.
